// File: rtl/dispatch_buffer_if.sv
// Decoder-to-dispatch-buffer instruction handshake.
// The decoder drives the master side; the buffer is the slave.
interface dispatch_buffer_if #(
    parameter int ROB_W = 4,
    parameter int OP_W  = 6,
    parameter int REG_W = 6
);
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_pc;
    logic [31:0]      in_imm;
    logic [REG_W-1:0] in_rd;
    logic [REG_W-1:0] in_rs1;
    logic [REG_W-1:0] in_rs2;
    logic [OP_W-1:0]  in_op;
    logic             in_is_ls;
    logic [ROB_W-1:0] in_entry;

    modport master (
        output in_valid, in_pc, in_imm, in_rd, in_rs1, in_rs2, in_op, in_is_ls, in_entry,
        input  in_ready
    );

    modport slave (
        input  in_valid, in_pc, in_imm, in_rd, in_rs1, in_rs2, in_op, in_is_ls, in_entry,
        output in_ready
    );
endinterface

// File: rtl/dispatch_buffer.sv
// Circular instruction buffer between decode and the reservation/load-store stations.
// Resolves pending operands against both CDBs as the head entry is dispatched.
module dispatch_buffer #(
    parameter int DEPTH = 4,
    parameter int ROB_W = 4,
    parameter int OP_W  = 6,
    parameter int REG_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rdy,
    input  logic             clear,
    dispatch_buffer_if.slave dec,
    output logic [REG_W-1:0] rs1_to_reg,
    output logic [REG_W-1:0] rs2_to_reg,
    input  logic [31:0]      Vj_from_reg,
    input  logic [31:0]      Vk_from_reg,
    input  logic [ROB_W-1:0] Qj_from_reg,
    input  logic [ROB_W-1:0] Qk_from_reg,
    input  logic             Qj_busy,
    input  logic             Qk_busy,
    input  logic             cdb_alu_valid,
    input  logic [ROB_W-1:0] cdb_alu_tag,
    input  logic [31:0]      cdb_alu_val,
    input  logic             cdb_lsb_valid,
    input  logic [ROB_W-1:0] cdb_lsb_tag,
    input  logic [31:0]      cdb_lsb_val,
    input  logic             rs_full,
    input  logic             lsb_full,
    output logic             is_rs,
    output logic             is_ls,
    output logic [31:0]      pc_out,
    output logic [31:0]      imm_out,
    output logic [31:0]      Vj,
    output logic [31:0]      Vk,
    output logic [ROB_W-1:0] Qj,
    output logic [ROB_W-1:0] Qk,
    output logic [ROB_W-1:0] entry_out,
    output logic             Qj_busy_out,
    output logic             Qk_busy_out,
    output logic [OP_W-1:0]  op_out,
    output logic [REG_W-1:0] rd_out
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef struct packed {
        logic [31:0]      pc;
        logic [31:0]      imm;
        logic [REG_W-1:0] rd;
        logic [REG_W-1:0] rs1;
        logic [REG_W-1:0] rs2;
        logic [OP_W-1:0]  op;
        logic             is_ls;
        logic [ROB_W-1:0] entry;
    } entry_t;

    entry_t          mem [DEPTH];
    entry_t          head_e;
    logic [AW-1:0]   head;
    logic [AW-1:0]   tail;
    logic [CW-1:0]   count;
    logic            enq;
    logic            deq;
    logic            target_full;
    logic [31:0]     vj_res;
    logic [31:0]     vk_res;
    logic            qj_busy_res;
    logic            qk_busy_res;

    assign head_e       = mem[head];
    assign rs1_to_reg   = head_e.rs1;
    assign rs2_to_reg   = head_e.rs2;
    // A full buffer refuses new work even if the head leaves this cycle.
    assign dec.in_ready = (count != CW'(DEPTH)) && !clear;
    assign enq          = dec.in_valid && dec.in_ready && rdy;
    assign target_full  = head_e.is_ls ? lsb_full : rs_full;
    assign deq          = rdy && !clear && (count != '0) && !target_full;

    // ALU broadcast takes priority when both buses carry the awaited tag.
    always_comb begin
        vj_res      = Vj_from_reg;
        qj_busy_res = Qj_busy;
        vk_res      = Vk_from_reg;
        qk_busy_res = Qk_busy;
        if (Qj_busy && cdb_alu_valid && cdb_alu_tag == Qj_from_reg) begin
            vj_res      = cdb_alu_val;
            qj_busy_res = 1'b0;
        end else if (Qj_busy && cdb_lsb_valid && cdb_lsb_tag == Qj_from_reg) begin
            vj_res      = cdb_lsb_val;
            qj_busy_res = 1'b0;
        end
        if (Qk_busy && cdb_alu_valid && cdb_alu_tag == Qk_from_reg) begin
            vk_res      = cdb_alu_val;
            qk_busy_res = 1'b0;
        end else if (Qk_busy && cdb_lsb_valid && cdb_lsb_tag == Qk_from_reg) begin
            vk_res      = cdb_lsb_val;
            qk_busy_res = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (enq) begin
            mem[tail] <= '{pc: dec.in_pc, imm: dec.in_imm, rd: dec.in_rd,
                           rs1: dec.in_rs1, rs2: dec.in_rs2, op: dec.in_op,
                           is_ls: dec.in_is_ls, entry: dec.in_entry};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head        <= '0;
            tail        <= '0;
            count       <= '0;
            is_rs       <= 1'b0;
            is_ls       <= 1'b0;
            pc_out      <= '0;
            imm_out     <= '0;
            Vj          <= '0;
            Vk          <= '0;
            Qj          <= '0;
            Qk          <= '0;
            entry_out   <= '0;
            Qj_busy_out <= 1'b0;
            Qk_busy_out <= 1'b0;
            op_out      <= '0;
            rd_out      <= '0;
        end else if (rdy) begin
            if (clear) begin
                head  <= '0;
                tail  <= '0;
                count <= '0;
                is_rs <= 1'b0;
                is_ls <= 1'b0;
            end else begin
                is_rs <= deq && !head_e.is_ls;
                is_ls <= deq && head_e.is_ls;
                if (enq) tail <= tail + AW'(1);
                if (deq) begin
                    head        <= head + AW'(1);
                    pc_out      <= head_e.pc;
                    imm_out     <= head_e.imm;
                    op_out      <= head_e.op;
                    rd_out      <= head_e.rd;
                    entry_out   <= head_e.entry;
                    Vj          <= vj_res;
                    Vk          <= vk_res;
                    Qj          <= Qj_from_reg;
                    Qk          <= Qk_from_reg;
                    Qj_busy_out <= qj_busy_res;
                    Qk_busy_out <= qk_busy_res;
                end
                if (enq && !deq)      count <= count + CW'(1);
                else if (!enq && deq) count <= count - CW'(1);
            end
        end
    end
endmodule

// File: tb/tb_dispatch_buffer.sv
// Directed bench for dispatch_buffer: table of single-instruction dispatch vectors
// followed by hand-written multi-cycle sequences (fill/drain, blocking, clear, reset).
module tb_dispatch_buffer;
    logic        clk = 1'b0;
    logic        rst, rdy, clear;
    logic [5:0]  rs1_to_reg, rs2_to_reg;
    logic [31:0] Vj_from_reg, Vk_from_reg;
    logic [3:0]  Qj_from_reg, Qk_from_reg;
    logic        Qj_busy, Qk_busy;
    logic        cdb_alu_valid, cdb_lsb_valid;
    logic [3:0]  cdb_alu_tag, cdb_lsb_tag;
    logic [31:0] cdb_alu_val, cdb_lsb_val;
    logic        rs_full, lsb_full;
    logic        is_rs, is_ls;
    logic [31:0] pc_out, imm_out, Vj, Vk;
    logic [3:0]  Qj, Qk, entry_out;
    logic        Qj_busy_out, Qk_busy_out;
    logic [5:0]  op_out, rd_out;

    int n_chk = 0;
    int n_err = 0;

    dispatch_buffer_if #(.ROB_W(4), .OP_W(6), .REG_W(6)) dec ();

    dispatch_buffer #(.DEPTH(4), .ROB_W(4), .OP_W(6), .REG_W(6)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .clear(clear), .dec(dec),
        .rs1_to_reg(rs1_to_reg), .rs2_to_reg(rs2_to_reg),
        .Vj_from_reg(Vj_from_reg), .Vk_from_reg(Vk_from_reg),
        .Qj_from_reg(Qj_from_reg), .Qk_from_reg(Qk_from_reg),
        .Qj_busy(Qj_busy), .Qk_busy(Qk_busy),
        .cdb_alu_valid(cdb_alu_valid), .cdb_alu_tag(cdb_alu_tag), .cdb_alu_val(cdb_alu_val),
        .cdb_lsb_valid(cdb_lsb_valid), .cdb_lsb_tag(cdb_lsb_tag), .cdb_lsb_val(cdb_lsb_val),
        .rs_full(rs_full), .lsb_full(lsb_full),
        .is_rs(is_rs), .is_ls(is_ls),
        .pc_out(pc_out), .imm_out(imm_out), .Vj(Vj), .Vk(Vk),
        .Qj(Qj), .Qk(Qk), .entry_out(entry_out),
        .Qj_busy_out(Qj_busy_out), .Qk_busy_out(Qk_busy_out),
        .op_out(op_out), .rd_out(rd_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        is_ls;
        logic [31:0] pc, imm;
        logic [5:0]  rd, rs1, rs2, op;
        logic [3:0]  entry;
        logic [31:0] vj_r, vk_r;
        logic [3:0]  qj_r, qk_r;
        logic        qjb, qkb;
        logic        av;
        logic [3:0]  at;
        logic [31:0] aval;
        logic        lv;
        logic [3:0]  lt;
        logic [31:0] lval;
        logic [31:0] e_vj, e_vk;
        logic        e_qjb, e_qkb;
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic ls, input logic [31:0] pc);
        dec.in_valid = 1'b1;
        dec.in_is_ls = ls;
        dec.in_pc    = pc;
        dec.in_imm   = ~pc;
        dec.in_rd    = pc[5:0];
        dec.in_rs1   = pc[7:2];
        dec.in_rs2   = pc[9:4];
        dec.in_op    = pc[5:0] ^ 6'h15;
        dec.in_entry = pc[3:0];
        step();
        dec.in_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{1'b0, 32'h1000, 32'h10, 6'd1, 6'd2, 6'd3, 6'h0A, 4'd1,
                    32'h1234, 32'h5678, 4'd3, 4'd4, 1'b0, 1'b0,
                    1'b1, 4'd3, 32'h99, 1'b0, 4'd0, 32'h0,
                    32'h1234, 32'h5678, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 32'h1004, 32'h20, 6'd4, 6'd5, 6'd6, 6'h0B, 4'd2,
                    32'hAAAA, 32'hBBBB, 4'd3, 4'd5, 1'b1, 1'b1,
                    1'b1, 4'd3, 32'h55, 1'b0, 4'd0, 32'h0,
                    32'h55, 32'hBBBB, 1'b0, 1'b1};
        vecs[2] = '{1'b0, 32'h1008, 32'h30, 6'd7, 6'd8, 6'd9, 6'h0C, 4'd3,
                    32'h0, 32'h0, 4'd3, 4'd3, 1'b1, 1'b1,
                    1'b1, 4'd3, 32'h11, 1'b1, 4'd3, 32'h22,
                    32'h11, 32'h11, 1'b0, 1'b0};
        vecs[3] = '{1'b1, 32'h100C, 32'h40, 6'd10, 6'd11, 6'd12, 6'h21, 4'd4,
                    32'h1, 32'h2, 4'd7, 4'd6, 1'b1, 1'b0,
                    1'b1, 4'd6, 32'h77, 1'b1, 4'd7, 32'hABCD,
                    32'hABCD, 32'h2, 1'b0, 1'b0};
        vecs[4] = '{1'b0, 32'h1010, 32'h50, 6'd13, 6'd14, 6'd15, 6'h0D, 4'd5,
                    32'h3333, 32'h4444, 4'd9, 4'd9, 1'b1, 1'b1,
                    1'b0, 4'd9, 32'h66, 1'b0, 4'd9, 32'h88,
                    32'h3333, 32'h4444, 1'b1, 1'b1};
        vecs[5] = '{1'b1, 32'h1014, 32'h60, 6'd16, 6'd17, 6'd18, 6'h22, 4'd6,
                    32'h5, 32'h6, 4'd2, 4'd8, 1'b1, 1'b1,
                    1'b1, 4'd8, 32'hE0, 1'b1, 4'd2, 32'hF0,
                    32'hF0, 32'hE0, 1'b0, 1'b0};

        rst = 1'b1; rdy = 1'b1; clear = 1'b0;
        dec.in_valid = 1'b0; dec.in_pc = '0; dec.in_imm = '0; dec.in_rd = '0;
        dec.in_rs1 = '0; dec.in_rs2 = '0; dec.in_op = '0; dec.in_is_ls = 1'b0; dec.in_entry = '0;
        Vj_from_reg = '0; Vk_from_reg = '0; Qj_from_reg = '0; Qk_from_reg = '0;
        Qj_busy = 1'b0; Qk_busy = 1'b0;
        cdb_alu_valid = 1'b0; cdb_alu_tag = '0; cdb_alu_val = '0;
        cdb_lsb_valid = 1'b0; cdb_lsb_tag = '0; cdb_lsb_val = '0;
        rs_full = 1'b0; lsb_full = 1'b0;
        step(); step();
        rst = 1'b0;
        #1;
        chk("reset in_ready", 32'(dec.in_ready), 32'd1);
        chk("reset is_rs", 32'(is_rs), 32'd0);
        chk("reset is_ls", 32'(is_ls), 32'd0);
        chk("reset pc_out", pc_out, 32'd0);
        step();
        chk("idle no strobe", 32'({is_rs, is_ls}), 32'd0);

        // Table vectors: enqueue, present operands, dispatch, then observe hold.
        for (int i = 0; i < 6; i++) begin
            dec.in_valid = 1'b1;
            dec.in_is_ls = vecs[i].is_ls; dec.in_pc = vecs[i].pc; dec.in_imm = vecs[i].imm;
            dec.in_rd = vecs[i].rd; dec.in_rs1 = vecs[i].rs1; dec.in_rs2 = vecs[i].rs2;
            dec.in_op = vecs[i].op; dec.in_entry = vecs[i].entry;
            step();
            dec.in_valid = 1'b0;
            Vj_from_reg = vecs[i].vj_r; Vk_from_reg = vecs[i].vk_r;
            Qj_from_reg = vecs[i].qj_r; Qk_from_reg = vecs[i].qk_r;
            Qj_busy = vecs[i].qjb; Qk_busy = vecs[i].qkb;
            cdb_alu_valid = vecs[i].av; cdb_alu_tag = vecs[i].at; cdb_alu_val = vecs[i].aval;
            cdb_lsb_valid = vecs[i].lv; cdb_lsb_tag = vecs[i].lt; cdb_lsb_val = vecs[i].lval;
            #1;
            chk($sformatf("v%0d rs1_to_reg", i), 32'(rs1_to_reg), 32'(vecs[i].rs1));
            chk($sformatf("v%0d rs2_to_reg", i), 32'(rs2_to_reg), 32'(vecs[i].rs2));
            step();
            chk($sformatf("v%0d is_rs", i), 32'(is_rs), 32'(!vecs[i].is_ls));
            chk($sformatf("v%0d is_ls", i), 32'(is_ls), 32'(vecs[i].is_ls));
            chk($sformatf("v%0d pc_out", i), pc_out, vecs[i].pc);
            chk($sformatf("v%0d imm_out", i), imm_out, vecs[i].imm);
            chk($sformatf("v%0d op_out", i), 32'(op_out), 32'(vecs[i].op));
            chk($sformatf("v%0d rd_out", i), 32'(rd_out), 32'(vecs[i].rd));
            chk($sformatf("v%0d entry_out", i), 32'(entry_out), 32'(vecs[i].entry));
            chk($sformatf("v%0d Vj", i), Vj, vecs[i].e_vj);
            chk($sformatf("v%0d Vk", i), Vk, vecs[i].e_vk);
            chk($sformatf("v%0d Qj_busy_out", i), 32'(Qj_busy_out), 32'(vecs[i].e_qjb));
            chk($sformatf("v%0d Qk_busy_out", i), 32'(Qk_busy_out), 32'(vecs[i].e_qkb));
            cdb_alu_valid = 1'b0; cdb_lsb_valid = 1'b0; Qj_busy = 1'b0; Qk_busy = 1'b0;
            step();
            chk($sformatf("v%0d strobe drops", i), 32'({is_rs, is_ls}), 32'd0);
            chk($sformatf("v%0d pc holds", i), pc_out, vecs[i].pc);
        end

        // Back-to-back stream: simultaneous enqueue and dispatch each cycle.
        dec.in_valid = 1'b1; dec.in_is_ls = 1'b0; dec.in_pc = 32'h400;
        step();
        dec.in_pc = 32'h404;
        step();
        chk("stream 0 is_rs", 32'(is_rs), 32'd1);
        chk("stream 0 pc", pc_out, 32'h400);
        dec.in_pc = 32'h408;
        step();
        chk("stream 1 is_rs", 32'(is_rs), 32'd1);
        chk("stream 1 pc", pc_out, 32'h404);
        dec.in_valid = 1'b0;
        step();
        chk("stream 2 is_rs", 32'(is_rs), 32'd1);
        chk("stream 2 pc", pc_out, 32'h408);
        step();
        chk("stream end", 32'({is_rs, is_ls}), 32'd0);

        // Fill to capacity behind a full station, then drain in order.
        rs_full = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("fill %0d in_ready", i), 32'(dec.in_ready), 32'd1);
            push(1'b0, 32'h100 + 32'(i));
        end
        chk("full in_ready", 32'(dec.in_ready), 32'd0);
        chk("full no strobe", 32'(is_rs), 32'd0);
        dec.in_valid = 1'b1; dec.in_pc = 32'h104; dec.in_is_ls = 1'b0;
        rs_full = 1'b0;
        step();
        dec.in_valid = 1'b0;
        chk("drain 0 is_rs", 32'(is_rs), 32'd1);
        chk("drain 0 pc", pc_out, 32'h100);
        for (int i = 1; i < 4; i++) begin
            step();
            chk($sformatf("drain %0d is_rs", i), 32'(is_rs), 32'd1);
            chk($sformatf("drain %0d pc", i), pc_out, 32'h100 + 32'(i));
        end
        step();
        chk("full refused push", 32'(is_rs), 32'd0);

        // Load/store head blocked by lsb_full while rs is free; ALU entry waits behind it.
        lsb_full = 1'b1;
        push(1'b1, 32'h300);
        push(1'b0, 32'h304);
        step();
        chk("ls blocked", 32'({is_rs, is_ls}), 32'd0);
        lsb_full = 1'b0;
        step();
        chk("ls release is_ls", 32'(is_ls), 32'd1);
        chk("ls release is_rs", 32'(is_rs), 32'd0);
        chk("ls release pc", pc_out, 32'h300);
        step();
        chk("after ls is_rs", 32'(is_rs), 32'd1);
        chk("after ls pc", pc_out, 32'h304);
        step();
        chk("after ls idle", 32'({is_rs, is_ls}), 32'd0);

        // Flush with three entries queued while a new instruction is offered.
        rs_full = 1'b1;
        push(1'b0, 32'h500);
        push(1'b0, 32'h504);
        push(1'b0, 32'h508);
        clear = 1'b1; dec.in_valid = 1'b1; dec.in_pc = 32'h50C;
        #1;
        chk("clear in_ready low", 32'(dec.in_ready), 32'd0);
        step();
        clear = 1'b0; dec.in_valid = 1'b0; rs_full = 1'b0;
        #1;
        chk("post clear in_ready", 32'(dec.in_ready), 32'd1);
        chk("post clear strobe", 32'({is_rs, is_ls}), 32'd0);
        step();
        chk("post clear empty 1", 32'({is_rs, is_ls}), 32'd0);
        step();
        chk("post clear empty 2", 32'({is_rs, is_ls}), 32'd0);

        // rdy low holds the strobe; async reset then wipes everything.
        push(1'b0, 32'h600);
        dec.in_valid = 1'b1; dec.in_pc = 32'h604; dec.in_is_ls = 1'b0;
        step();
        dec.in_valid = 1'b0;
        chk("pre-hold is_rs", 32'(is_rs), 32'd1);
        chk("pre-hold pc", pc_out, 32'h600);
        rdy = 1'b0;
        step();
        chk("hold 1 is_rs", 32'(is_rs), 32'd1);
        step();
        chk("hold 2 is_rs", 32'(is_rs), 32'd1);
        chk("hold 2 pc", pc_out, 32'h600);
        rdy = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        chk("async rst is_rs", 32'(is_rs), 32'd0);
        chk("async rst pc", pc_out, 32'd0);
        chk("async rst entry", 32'(entry_out), 32'd0);
        chk("async rst in_ready", 32'(dec.in_ready), 32'd1);
        step();
        rst = 1'b0;
        step();
        chk("post rst idle 1", 32'({is_rs, is_ls}), 32'd0);
        step();
        chk("post rst idle 2", 32'({is_rs, is_ls}), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/dispatch_buffer.md
DISPATCH_BUFFER -- requirements
Module: dispatch_buffer

Interface
REQ-001 Parameter DEPTH, default 4, meaning buffer entries; power of two, at least 2.
REQ-002 Parameter ROB_W, default 4, meaning ROB entry tag width.
REQ-003 Parameter OP_W, default 6, meaning op code width.
REQ-004 Parameter REG_W, default 6, meaning register index width.
REQ-005 Port clk  input  1  single clock, rising edge.
REQ-006 Port rst  input  1  reset, asynchronous, active-high.
REQ-007 Port rdy  input  1  global enable; low freezes all state.
REQ-008 Port clear  input  1  mispredict flush, synchronous.
REQ-009 Port in_valid  input  1  decoded instruction present.
REQ-010 Port in_ready  output  1  buffer can accept this cycle.
REQ-011 Port in_pc, in_imm  input  32 each  instruction PC and immediate.
REQ-012 Port in_rd, in_rs1, in_rs2  input  REG_W each  register indices.
REQ-013 Port in_op  input  OP_W  op code; in_is_ls  input  1  load/store flag; in_entry  input  ROB_W  ROB tag.
REQ-014 Port rs1_to_reg, rs2_to_reg  output  REG_W each  head-entry source indices.
REQ-015 Port Vj_from_reg, Vk_from_reg  input  32; Qj_from_reg, Qk_from_reg  input  ROB_W; Qj_busy, Qk_busy  input  1  operand pending.
REQ-016 Port cdb_alu_valid, cdb_lsb_valid  input  1; cdb_alu_tag, cdb_lsb_tag  input  ROB_W; cdb_alu_val, cdb_lsb_val  input  32  result broadcasts.
REQ-017 Port rs_full, lsb_full  input  1  target station cannot accept.
REQ-018 Port is_rs, is_ls  output  1  one-cycle dispatch strobes.
REQ-019 Port pc_out, imm_out, Vj, Vk  output  32; Qj, Qk, entry_out  output  ROB_W; Qj_busy_out, Qk_busy_out  output  1; op_out  output  OP_W; rd_out  output  REG_W.

Function
REQ-020 Buffer SHALL be a circular FIFO of DEPTH entries with head/tail pointers wrapping modulo DEPTH and a count of width clog2(DEPTH)+1.
REQ-021 in_ready SHALL equal (count != DEPTH) && !clear; enqueue occurs on edge when in_valid && in_ready && rdy.
REQ-022 Full buffer SHALL NOT accept even if a dequeue occurs the same cycle.
REQ-023 rs1_to_reg/rs2_to_reg SHALL combinationally present the head entry's rs1/rs2.
REQ-024 Dispatch condition: rdy && !clear && count != 0 && !(head.is_ls ? lsb_full : rs_full).
REQ-025 On dispatch edge: head pops, output registers load head payload, exactly one of is_ls/is_rs = 1 per head.is_ls for one cycle.
REQ-026 Operand resolution at dispatch: if Qx_busy and a valid CDB tag equals Qx_from_reg, Vx = CDB value, Qx_busy_out = 0; ALU CDB checked before LSB CDB; otherwise Vx/Qx/busy pass from regfile.
REQ-027 Cycles without dispatch SHALL drive is_rs = is_ls = 0; payload registers hold.
REQ-028 Simultaneous enqueue and dispatch SHALL leave count unchanged and advance both pointers.
REQ-029 Minimum latency: instruction enqueued at edge N strobes after edge N+1.
REQ-030 clear SHALL zero head, tail, count and strobes on the next edge, ignoring in_valid.
REQ-031 rdy low SHALL hold every register, strobes included.
REQ-032 Throughput: one dispatch per cycle when target not full.

Reset
REQ-033 rst high SHALL immediately zero head, tail, count, is_rs, is_ls and all payload outputs; in_ready = 1 after release.
REQ-034 Reset mid-operation discards all entries; no strobe until new enqueue.

Verification
REQ-035 Fill 4 ALU ops with rs_full=1 -> in_ready=0 after 4th; release rs_full -> four is_rs strobes in order, consecutive cycles.
REQ-036 Head load, lsb_full=1, rs_full=0 -> no dispatch, queue blocked until lsb_full=0, then is_ls=1.
REQ-037 Qj_busy=1, Qj_from_reg=3, cdb_alu_valid=1, tag=3, val=0x55 at dispatch -> Vj=0x55, Qj_busy_out=0.
REQ-038 Both CDBs carry tag 3 (0x11 ALU, 0x22 LSB) -> Vj=0x11.
REQ-039 clear with 3 entries plus in_valid=1 -> count=0, no strobes, in_ready=1 next cycle.
REQ-040 rst asserted mid-dispatch, rdy=0 for 2 cycles otherwise -> outputs zero asynchronously; rdy low holds strobe value unchanged.
